// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - two-requester arbiter sharing one 64-bit / dual 32-bit comparator

// Shared comparator: lane A is the full 64-bit compare in wide mode or the low
// 32-bit compare in narrow mode; lane B is always the upper 32-bit compare.
module comparator64 (
  input  logic        mode,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        eq_a,
  output logic        slt_a,
  output logic        ult_a,
  output logic        eq_b,
  output logic        slt_b,
  output logic        ult_b
);

  // Lane results from the registered operands
  always_comb begin
    if (mode) begin
      eq_a  = (a == b);
      slt_a = ($signed(a) < $signed(b));
      ult_a = (a < b);
    end else begin
      eq_a  = (a[31:0] == b[31:0]);
      slt_a = ($signed(a[31:0]) < $signed(b[31:0]));
      ult_a = (a[31:0] < b[31:0]);
    end
    eq_b  = (a[63:32] == b[63:32]);
    slt_b = ($signed(a[63:32]) < $signed(b[63:32]));
    ult_b = (a[63:32] < b[63:32]);
  end

endmodule

module cmp_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_wide,
  input  logic [63:0]      r0_a,
  input  logic [63:0]      r0_b,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_wide,
  input  logic [63:0]      r1_a,
  input  logic [63:0]      r1_b,
  input  logic [TAG_W-1:0] r1_tag,
  output logic             s0_valid,
  input  logic             s0_ready,
  output logic             s0_eq,
  output logic             s0_slt,
  output logic             s0_ult,
  output logic [TAG_W-1:0] s0_tag,
  output logic             s1_valid,
  input  logic             s1_ready,
  output logic             s1_eq,
  output logic             s1_slt,
  output logic             s1_ult,
  output logic [TAG_W-1:0] s1_tag,
  output logic [CNT_W-1:0] cnt_issue,
  output logic [CNT_W-1:0] cnt_pair
);

  logic busy0, busy1, ptr;
  logic elig0, elig1, pair, grant0, grant1;

  logic        iss_mode;
  logic [63:0] iss_a, iss_b;

  logic             st_valid, st_own0, st_own1, st_pair, st_mode;
  logic [63:0]      st_a, st_b;
  logic [TAG_W-1:0] st_tag0, st_tag1;

  logic eq_a, slt_a, ult_a, eq_b, slt_b, ult_b;

  // Arbitration: pair two narrow ops, else round-robin, else lone grant
  always_comb begin
    elig0  = r0_valid && !busy0;
    elig1  = r1_valid && !busy1;
    pair   = elig0 && elig1 && !r0_wide && !r1_wide;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (pair) begin
      grant0 = 1'b1;
      grant1 = 1'b1;
    end else if (elig0 && elig1) begin
      grant0 = !ptr;
      grant1 = ptr;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Operand packing: paired ops share lanes, lone narrow ops zero the upper half
  always_comb begin
    iss_mode = 1'b0;
    iss_a    = 64'd0;
    iss_b    = 64'd0;
    if (pair) begin
      iss_a = {r1_a[31:0], r0_a[31:0]};
      iss_b = {r1_b[31:0], r0_b[31:0]};
    end else if (grant0) begin
      iss_mode = r0_wide;
      iss_a    = r0_wide ? r0_a : {32'd0, r0_a[31:0]};
      iss_b    = r0_wide ? r0_b : {32'd0, r0_b[31:0]};
    end else if (grant1) begin
      iss_mode = r1_wide;
      iss_a    = r1_wide ? r1_a : {32'd0, r1_a[31:0]};
      iss_b    = r1_wide ? r1_b : {32'd0, r1_b[31:0]};
    end
  end

  // Stage-1 control: issue valid, lane ownership, round-robin pointer, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid  <= 1'b0;
      st_own0   <= 1'b0;
      st_own1   <= 1'b0;
      st_pair   <= 1'b0;
      ptr       <= 1'b0;
      cnt_issue <= '0;
      cnt_pair  <= '0;
    end else begin
      st_valid <= grant0 || grant1;
      st_own0  <= grant0;
      st_own1  <= grant1;
      st_pair  <= pair;
      if (elig0 && elig1 && !pair) ptr <= !ptr;
      if (grant0 || grant1) cnt_issue <= cnt_issue + CNT_W'(1);
      if (pair) cnt_pair <= cnt_pair + CNT_W'(1);
    end
  end

  // Stage-1 datapath registers feeding the comparator
  always_ff @(posedge clk) begin
    if (grant0 || grant1) begin
      st_mode <= iss_mode;
      st_a    <= iss_a;
      st_b    <= iss_b;
      st_tag0 <= r0_tag;
      st_tag1 <= r1_tag;
    end
  end

  comparator64 u_cmp (
    .mode  (st_mode),
    .a     (st_a),
    .b     (st_b),
    .eq_a  (eq_a),
    .slt_a (slt_a),
    .ult_a (ult_a),
    .eq_b  (eq_b),
    .slt_b (slt_b),
    .ult_b (ult_b)
  );

  // Outstanding-transaction flags: set on acceptance, cleared on response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      busy0 <= 1'b0;
      busy1 <= 1'b0;
    end else begin
      if (grant0) busy0 <= 1'b1;
      else if (s0_valid && s0_ready) busy0 <= 1'b0;
      if (grant1) busy1 <= 1'b1;
      else if (s1_valid && s1_ready) busy1 <= 1'b0;
    end
  end

  // Stage-2 response registers, held until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_eq    <= 1'b0;
      s0_slt   <= 1'b0;
      s0_ult   <= 1'b0;
      s0_tag   <= '0;
      s1_valid <= 1'b0;
      s1_eq    <= 1'b0;
      s1_slt   <= 1'b0;
      s1_ult   <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (st_valid && st_own0) begin
        s0_valid <= 1'b1;
        s0_eq    <= eq_a;
        s0_slt   <= slt_a;
        s0_ult   <= ult_a;
        s0_tag   <= st_tag0;
      end else if (s0_valid && s0_ready) begin
        s0_valid <= 1'b0;
      end
      if (st_valid && st_own1) begin
        s1_valid <= 1'b1;
        s1_eq    <= st_pair ? eq_b  : eq_a;
        s1_slt   <= st_pair ? slt_b : slt_a;
        s1_ult   <= st_pair ? ult_b : ult_a;
        s1_tag   <= st_tag1;
      end else if (s1_valid && s1_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter
module tb_cmp_arbiter;

  localparam int TAG_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       rv = '0, rw = '0, sr = '0;
  logic [63:0]      ra [2];
  logic [63:0]      rb [2];
  logic [TAG_W-1:0] rt [2];

  logic             r0_ready, r1_ready;
  logic             s0_valid, s0_eq, s0_slt, s0_ult;
  logic             s1_valid, s1_eq, s1_slt, s1_ult;
  logic [TAG_W-1:0] s0_tag, s1_tag;
  logic [CNT_W-1:0] cnt_issue, cnt_pair;

  cmp_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(rv[0]), .r0_ready(r0_ready), .r0_wide(rw[0]), .r0_a(ra[0]), .r0_b(rb[0]), .r0_tag(rt[0]),
    .r1_valid(rv[1]), .r1_ready(r1_ready), .r1_wide(rw[1]), .r1_a(ra[1]), .r1_b(rb[1]), .r1_tag(rt[1]),
    .s0_valid(s0_valid), .s0_ready(sr[0]), .s0_eq(s0_eq), .s0_slt(s0_slt), .s0_ult(s0_ult), .s0_tag(s0_tag),
    .s1_valid(s1_valid), .s1_ready(sr[1]), .s1_eq(s1_eq), .s1_slt(s1_slt), .s1_ult(s1_ult), .s1_tag(s1_tag),
    .cnt_issue(cnt_issue), .cnt_pair(cnt_pair)
  );

  logic [1:0]       o_valid, o_eq, o_slt, o_ult;
  logic [TAG_W-1:0] o_tag [2];
  assign o_valid = {s1_valid, s0_valid};
  assign o_eq    = {s1_eq, s0_eq};
  assign o_slt   = {s1_slt, s0_slt};
  assign o_ult   = {s1_ult, s0_ult};
  assign o_tag[0] = s0_tag;
  assign o_tag[1] = s1_tag;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: per-requester transaction state and expected outputs
  logic [1:0]       m_busy = '0, m_infl = '0, m_sval = '0;
  logic [1:0]       m_eq = '0, m_slt = '0, m_ult = '0;
  logic [TAG_W-1:0] m_tag [2] = '{default: '0};
  logic [2:0]       m_res [2] = '{default: '0};
  logic [TAG_W-1:0] m_rtag [2] = '{default: '0};
  logic             m_ptr = 1'b0;
  logic [CNT_W-1:0] m_issue = '0, m_pair = '0;

  function automatic logic [2:0] ref_cmp(input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x, y;
    x = a[31:0];
    y = b[31:0];
    if (w) return {a == b, $signed(a) < $signed(b), a < b};
    return {x == y, $signed(x) < $signed(y), x < y};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model over the rising edge
  task automatic step();
    logic [1:0] e, g;
    logic pr;
    @(negedge clk);
    e[0] = rv[0] && !m_busy[0];
    e[1] = rv[1] && !m_busy[1];
    pr = e[0] && e[1] && !rw[0] && !rw[1];
    if (rst) g = 2'b00;
    else if (pr) g = 2'b11;
    else if (e == 2'b11) g = m_ptr ? 2'b10 : 2'b01;
    else g = e;
    chk("r0_ready", r0_ready, g[0]);
    chk("r1_ready", r1_ready, g[1]);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("s%0d_valid", n), o_valid[n], m_sval[n]);
      chk($sformatf("s%0d_eq", n), o_eq[n], m_eq[n]);
      chk($sformatf("s%0d_slt", n), o_slt[n], m_slt[n]);
      chk($sformatf("s%0d_ult", n), o_ult[n], m_ult[n]);
      chk($sformatf("s%0d_tag", n), o_tag[n], m_tag[n]);
    end
    chk("cnt_issue", cnt_issue, m_issue);
    chk("cnt_pair", cnt_pair, m_pair);
    if (rst) begin
      m_busy = '0; m_infl = '0; m_sval = '0;
      m_eq = '0; m_slt = '0; m_ult = '0;
      m_tag[0] = '0; m_tag[1] = '0;
      m_ptr = 1'b0; m_issue = '0; m_pair = '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (m_sval[n] && sr[n]) begin
          m_sval[n] = 1'b0;
          m_busy[n] = 1'b0;
        end
        if (m_infl[n]) begin
          m_sval[n] = 1'b1;
          {m_eq[n], m_slt[n], m_ult[n]} = m_res[n];
          m_tag[n] = m_rtag[n];
        end
        m_infl[n] = g[n];
        if (g[n]) begin
          m_busy[n] = 1'b1;
          m_res[n]  = ref_cmp(rw[n], ra[n], rb[n]);
          m_rtag[n] = rt[n];
        end
      end
      if (g != 2'b00) m_issue = m_issue + 1'b1;
      if (pr) m_pair = m_pair + 1'b1;
      if (e == 2'b11 && !pr) m_ptr = !m_ptr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rv = '0;
    sr = 2'b11;
    repeat (4) step();
  endtask

  task automatic rand_req(input int n);
    ra[n] = {$urandom, $urandom};
    rb[n] = ($urandom_range(0, 3) == 0) ? ra[n] : {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) rb[n][31] = ~rb[n][31];
    rt[n] = TAG_W'($urandom);
  endtask

  initial begin
    ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rt[0] = '0; rt[1] = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rv = 2'b11;
    step();
    step();
    rst = 1'b0;
    rv = '0;
    step();

    // Pairing of two narrow ops
    sr = 2'b00;
    rv = 2'b11; rw = 2'b00;
    ra[0] = 64'd5; rb[0] = 64'd7; rt[0] = 4'd1;
    ra[1] = 64'hFFFF_FFFF; rb[1] = 64'd0; rt[1] = 4'd2;
    step();
    rv = '0;
    step();
    chk("pair_s0_eq", s0_eq, 1'b0);
    chk("pair_s0_slt", s0_slt, 1'b1);
    chk("pair_s0_ult", s0_ult, 1'b1);
    chk("pair_s0_tag", s0_tag, 4'd1);
    chk("pair_s1_valid", s1_valid, 1'b1);
    chk("pair_s1_eq", s1_eq, 1'b0);
    chk("pair_s1_slt", s1_slt, 1'b1);
    chk("pair_s1_ult", s1_ult, 1'b0);
    chk("pair_s1_tag", s1_tag, 4'd2);
    chk("pair_cnt_pair", cnt_pair, 8'd1);
    drain();

    // Wide contention with pointer at requester 0
    sr = 2'b00;
    rv = 2'b11; rw = 2'b11;
    ra[0] = 64'h8000_0000_0000_0000; rb[0] = 64'd1; rt[0] = 4'd3;
    rand_req(1);
    #1;
    chk("wide_r0_first", {r1_ready, r0_ready}, 2'b01);
    step();
    #1;
    chk("wide_r1_next", r1_ready, 1'b1);
    step();
    step();
    chk("wide_s0_slt", s0_slt, 1'b1);
    chk("wide_s0_ult", s0_ult, 1'b0);

    // Backpressure on s0 with r0_valid held
    rv = 2'b01; sr = 2'b10;
    rand_req(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_r0_ready", r0_ready, 1'b0);
      step();
    end
    sr = 2'b11;
    step();
    #1;
    chk("bp_accept_after_hs", r0_ready, 1'b1);
    step();
    drain();

    // Mixed narrow/wide with pointer at requester 1
    if (!m_ptr) begin
      rv = 2'b11; rw = 2'b11;
      step();
      drain();
    end
    begin
      logic [CNT_W-1:0] base_i, base_p;
      base_i = m_issue;
      base_p = m_pair;
      rv = 2'b11; rw = 2'b10; sr = 2'b11;
      ra[0] = 64'hFFFF_0000_0000_0003; rb[0] = 64'h0000_0000_0000_0003; rt[0] = 4'd5;
      rand_req(1);
      #1;
      chk("mix_r1_first", {r1_ready, r0_ready}, 2'b10);
      step();
      rv = 2'b01;
      #1;
      chk("mix_r0_next", r0_ready, 1'b1);
      step();
      rv = 2'b00;
      step();
      chk("mix_cnt_issue", cnt_issue, base_i + 8'd2);
      chk("mix_cnt_pair", cnt_pair, base_p);
      chk("mix_s0_eq_narrow", s0_eq, 1'b1);
    end
    drain();

    // Counter wrap
    rv = 2'b01; sr = 2'b11;
    for (int i = 0; i < 2000 && m_issue != {CNT_W{1'b1}}; i++) begin
      rw[0] = 1'($urandom);
      rand_req(0);
      step();
    end
    chk("wrap_full", cnt_issue, {CNT_W{1'b1}});
    for (int i = 0; i < 10 && m_issue != '0; i++) step();
    chk("wrap_zero", cnt_issue, {CNT_W{1'b0}});
    drain();

    // Reset mid-operation
    rv = 2'b01; rw = 2'b01;
    rand_req(0);
    step();
    rv = 2'b00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_s0_valid", s0_valid, 1'b0);
    chk("rst_s0_tag", s0_tag, 4'd0);
    chk("rst_cnt_issue", cnt_issue, 8'd0);
    rv = 2'b01;
    #1;
    chk("rst_next_accept", r0_ready, 1'b1);
    step();
    rv = 2'b00;
    step();
    chk("rst_next_resp", s0_valid, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rv  = 2'($urandom);
      rw  = 2'($urandom);
      sr  = 2'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      rand_req(0);
      rand_req(1);
      step();
    end
    rst = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter TAG_W, default 4: width of the requester tag returned with each response.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Ports rN_valid (N=0,1), input, 1 each: requester N presents a compare request.
REQ-006 Ports rN_ready (N=0,1), output, 1 each: request N accepted this cycle (handshake = valid && ready at the edge).
REQ-007 Ports rN_wide (N=0,1), input, 1 each: 1 = 64-bit compare; 0 = 32-bit compare on bits [31:0] only.
REQ-008 Ports rN_a and rN_b (N=0,1), input, 64 each: operands.
REQ-009 Ports rN_tag (N=0,1), input, TAG_W each: opaque tag echoed on the response.
REQ-010 Ports sN_valid (N=0,1), output, 1 each: response N is held valid.
REQ-011 Ports sN_ready (N=0,1), input, 1 each: consumer N takes the response.
REQ-012 Ports sN_eq, sN_slt, sN_ult (N=0,1), output, 1 each: equal, signed-less-than and unsigned-less-than results.
REQ-013 Ports sN_tag (N=0,1), output, TAG_W each: echoed tag.
REQ-014 Ports cnt_issue and cnt_pair, output, CNT_W each: count of comparator issues, and of issues that carried two paired 32-bit ops.

Function
REQ-015 The block SHALL instantiate one comparator64 and share it between the two requesters.
REQ-016 Each requester SHALL have at most one outstanding transaction: busy_N sets on acceptance and clears on the sN handshake. A new acceptance for N is not allowed in the cycle busy_N clears.
REQ-017 Eligibility: elig_N = rN_valid && !busy_N.
REQ-018 Pairing: if elig_0 && elig_1 && !r0_wide && !r1_wide, both rN_ready SHALL assert, with mode=0, lower lane = r0 bits [31:0], upper lane = r1 bits [31:0].
REQ-019 Otherwise, if both requesters are eligible, only the requester at the round-robin pointer SHALL be granted, and the pointer SHALL move to the other requester.
REQ-020 Otherwise, a single eligible requester SHALL be granted; the pointer is unchanged.
REQ-021 A lone grant SHALL issue with mode = rN_wide. A narrow lone op uses the lower lane, and the upper 32 operand bits are driven to zero.
REQ-022 rN_ready SHALL be combinational from rN_valid, rN_wide, busy_N and the pointer; rN_ready = 0 whenever rN_valid = 0.
REQ-023 Stage 1: the edge of acceptance SHALL register the operands, mode, lane owners and tags; the comparator is driven from these registers.
REQ-024 Stage 2: the next edge SHALL load the response registers. The lower-lane or wide owner takes eqA/sltA/ultA; the upper-lane owner takes eqB/sltB/ultB.
REQ-025 Latency: a request accepted in cycle C SHALL have sN_valid = 1 from cycle C+2.
REQ-026 sN_valid and the sN result/tag outputs SHALL hold stable until sN_ready = 1.
REQ-027 cnt_issue SHALL increment by 1 per issue cycle; cnt_pair SHALL increment by 1 per paired issue; both wrap modulo 2^CNT_W with no saturation.
REQ-028 sN_ready may be asserted without sN_valid; this SHALL have no effect.

Reset
REQ-029 While rst = 1 at an edge, the block SHALL clear busy_N, the stage-1 valid, sN_valid, sN_eq/slt/ult, sN_tag, the pointer (requester 0 first), cnt_issue and cnt_pair to 0.
REQ-030 Reset asserted mid-transaction SHALL discard in-flight ops with no response produced; rN_ready = 0 while rst = 1.

Verification
REQ-031 Pairing: r0 = {a=5, b=7, narrow, tag 1} and r1 = {a=32'hFFFFFFFF, b=0, narrow, tag 2} in the same cycle -> both accepted.
  - s0 = eq 0, slt 1, ult 1, tag 1.
  - s1 = eq 0, slt 1, ult 0, tag 2; both at C+2.
  - cnt_pair = 1.
REQ-032 Wide contention: both requesters wide, valid held, pointer = 0.
  - r0 is granted in cycle C and r1 in cycle C+1.
  - r0 with a=64'h8000_0000_0000_0000, b=1 -> s0_slt = 1, s0_ult = 0.
REQ-033 Backpressure: s0_ready = 0 for 5 cycles with r0_valid held high.
  - r0_ready stays 0 and the s0 outputs stay stable.
  - r0 is accepted one cycle after the s0 handshake.
REQ-034 Mixed: r0 narrow, r1 wide, both eligible, pointer = 1.
  - r1 is issued in mode 1; r0 is issued the next cycle in mode 0, lower lane.
  - cnt_issue += 2, cnt_pair += 0.
REQ-035 Counter wrap: force 2^CNT_W - 1 issues, then one more -> cnt_issue = 0.
REQ-036 Reset mid-op: rst pulsed in cycle C+1 after an accept in cycle C.
  - No sN_valid is produced; all outputs are 0; the next request is accepted normally.
